// File: rtl/mem_lsu_pkg.sv
// Shared widths, load/store operation codes and FSM encoding for the
// memory load/store unit.
package mem_lsu_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int AluOpBus   = 8;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   localparam logic [AluOpBus-1:0] OP_LB  = 8'b1110_0000;
   localparam logic [AluOpBus-1:0] OP_LH  = 8'b1110_0001;
   localparam logic [AluOpBus-1:0] OP_LW  = 8'b1110_0011;
   localparam logic [AluOpBus-1:0] OP_LBU = 8'b1110_0100;
   localparam logic [AluOpBus-1:0] OP_LHU = 8'b1110_0101;
   localparam logic [AluOpBus-1:0] OP_SB  = 8'b1110_1000;
   localparam logic [AluOpBus-1:0] OP_SH  = 8'b1110_1001;
   localparam logic [AluOpBus-1:0] OP_SW  = 8'b1110_1011;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: memory-op decode, misalignment detect, store
// byte enables and replication, load lane extraction with extension.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [AluOpBus-1:0] aluop,
   input  logic [1:0]          offset,
   input  logic [RegBus-1:0]   sdata,
   input  logic [RegBus-1:0]   rdata,
   output logic                is_mem,
   output logic                is_load,
   output logic                misalign,
   output logic [3:0]          be,
   output logic [RegBus-1:0]   store_data,
   output logic [RegBus-1:0]   load_data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   assign lane_byte = rdata[{offset, 3'b000} +: 8];
   assign lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

   // Loads always fetch the full word; the lane is picked on the way back.
   always_comb begin
      is_mem     = 1'b0;
      is_load    = 1'b0;
      misalign   = 1'b0;
      be         = 4'b1111;
      store_data = sdata;
      load_data  = rdata;
      case (aluop)
         OP_LB: begin
            is_mem    = 1'b1;
            is_load   = 1'b1;
            load_data = {{24{lane_byte[7]}}, lane_byte};
         end
         OP_LBU: begin
            is_mem    = 1'b1;
            is_load   = 1'b1;
            load_data = {24'b0, lane_byte};
         end
         OP_LH: begin
            is_mem    = 1'b1;
            is_load   = 1'b1;
            misalign  = offset[0];
            load_data = {{16{lane_half[15]}}, lane_half};
         end
         OP_LHU: begin
            is_mem    = 1'b1;
            is_load   = 1'b1;
            misalign  = offset[0];
            load_data = {16'b0, lane_half};
         end
         OP_LW: begin
            is_mem   = 1'b1;
            is_load  = 1'b1;
            misalign = (offset != 2'b00);
         end
         OP_SB: begin
            is_mem     = 1'b1;
            be         = 4'b0001 << offset;
            store_data = {4{sdata[7:0]}};
         end
         OP_SH: begin
            is_mem     = 1'b1;
            misalign   = offset[0];
            be         = offset[1] ? 4'b1100 : 4'b0011;
            store_data = {2{sdata[15:0]}};
         end
         OP_SW: begin
            is_mem   = 1'b1;
            misalign = (offset != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between ex and writeback: passes ALU results through and
// runs one outstanding data-memory access at a time.
module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [AluOpBus-1:0]   aluop_i,
   input  logic [RegAddrBus-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [RegBus-1:0]     wdata_i,
   input  logic [RegBus-1:0]     sdata_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [RegBus-1:0]     dmem_addr_o,
   output logic [3:0]            dmem_be_o,
   output logic [RegBus-1:0]     dmem_wdata_o,
   input  logic                  dmem_ack_i,
   input  logic [RegBus-1:0]     dmem_rdata_i,
   input  logic                  dmem_err_i,
   output logic                  wb_valid_o,
   output logic [RegAddrBus-1:0] wd_o,
   output logic                  wreg_o,
   output logic [RegBus-1:0]     wdata_o,
   output logic                  stall_req_o,
   output logic                  misalign_o,
   output logic                  buserr_o
);

   lsu_state_e state, state_next;

   logic [AluOpBus-1:0]   op_q;
   logic [1:0]            offset_q;
   logic [RegAddrBus-1:0] wd_q;
   logic                  wreg_q;

   logic [AluOpBus-1:0] align_op;
   logic [1:0]          align_offset;
   logic                is_mem, is_load, misalign;
   logic [3:0]          be;
   logic [RegBus-1:0]   store_data, load_data;
   logic                accept, start_access, ack_seen;

   // One lane unit serves both phases: ex inputs while idle, the latched op while busy.
   assign align_op     = (state == BUSY) ? op_q : aluop_i;
   assign align_offset = (state == BUSY) ? offset_q : wdata_i[1:0];

   lsu_align u_align (
      .aluop      (align_op),
      .offset     (align_offset),
      .sdata      (sdata_i),
      .rdata      (dmem_rdata_i),
      .is_mem     (is_mem),
      .is_load    (is_load),
      .misalign   (misalign),
      .be         (be),
      .store_data (store_data),
      .load_data  (load_data)
   );

   assign accept       = (state == IDLE) & ex_valid_i;
   assign start_access = accept & is_mem & ~misalign;
   assign ack_seen     = (state == BUSY) & dmem_ack_i;
   assign ex_ready_o   = (state == IDLE);
   assign stall_req_o  = (state == BUSY) | (accept & is_mem);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_access) state_next = BUSY;
         BUSY:    if (dmem_ack_i)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Fault and writeback pulses clear every cycle; wreg_o only rides with wb_valid_o.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= ZeroWord;
         dmem_be_o    <= 4'b0000;
         dmem_wdata_o <= ZeroWord;
         wb_valid_o   <= 1'b0;
         wd_o         <= '0;
         wreg_o       <= 1'b0;
         wdata_o      <= ZeroWord;
         misalign_o   <= 1'b0;
         buserr_o     <= 1'b0;
         op_q         <= '0;
         offset_q     <= 2'b00;
         wd_q         <= '0;
         wreg_q       <= 1'b0;
      end else begin
         wb_valid_o <= 1'b0;
         wreg_o     <= 1'b0;
         misalign_o <= 1'b0;
         buserr_o   <= 1'b0;
         if (accept) begin
            if (!is_mem) begin
               wb_valid_o <= 1'b1;
               wd_o       <= wd_i;
               wreg_o     <= wreg_i & (wd_i != '0);
               wdata_o    <= wdata_i;
            end else if (misalign) begin
               wb_valid_o <= 1'b1;
               wd_o       <= wd_i;
               misalign_o <= 1'b1;
            end else begin
               dmem_req_o   <= 1'b1;
               dmem_we_o    <= ~is_load;
               dmem_addr_o  <= {wdata_i[RegBus-1:2], 2'b00};
               dmem_be_o    <= be;
               dmem_wdata_o <= store_data;
               op_q         <= aluop_i;
               offset_q     <= wdata_i[1:0];
               wd_q         <= wd_i;
               wreg_q       <= wreg_i;
            end
         end else if (ack_seen) begin
            dmem_req_o <= 1'b0;
            wb_valid_o <= 1'b1;
            wd_o       <= wd_q;
            if (dmem_err_i) begin
               buserr_o <= 1'b1;
            end else if (is_load) begin
               wdata_o <= load_data;
               wreg_o  <= wreg_q & (wd_q != '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected writebacks are queued as stimulus
// is issued and compared when the unit raises wb_valid_o.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam logic [7:0] OP_OR  = 8'b0010_0101;
   localparam logic [7:0] OP_ADD = 8'b0010_0000;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        mis;
      logic        berr;
   } wb_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid_i, ex_ready_o;
   logic [7:0]  aluop_i;
   logic [4:0]  wd_i, wd_o;
   logic        wreg_i, wreg_o;
   logic [31:0] wdata_i, sdata_i, wdata_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i, dmem_err_i;
   logic        wb_valid_o, stall_req_o, misalign_o, buserr_o;

   wb_exp_t     sb_queue[$];
   logic [31:0] model_wdata = 32'h0;
   int          check_count = 0;
   int          pass_count  = 0;
   bit          running     = 1'b0;

   mem_lsu dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid_i   (ex_valid_i),
      .ex_ready_o   (ex_ready_o),
      .aluop_i      (aluop_i),
      .wd_i         (wd_i),
      .wreg_i       (wreg_i),
      .wdata_i      (wdata_i),
      .sdata_i      (sdata_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_ack_i   (dmem_ack_i),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_err_i   (dmem_err_i),
      .wb_valid_o   (wb_valid_o),
      .wd_o         (wd_o),
      .wreg_o       (wreg_o),
      .wdata_o      (wdata_o),
      .stall_req_o  (stall_req_o),
      .misalign_o   (misalign_o),
      .buserr_o     (buserr_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
   endtask

   task automatic pushWb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic mis, input logic berr);
      wb_exp_t e;
      e.wd    = wd;
      e.wreg  = wreg && (wd != 5'd0);
      e.wdata = wdata;
      e.mis   = mis;
      e.berr  = berr;
      sb_queue.push_back(e);
   endtask

   // Drive one ex result at a negedge; returns at the negedge after acceptance.
   task automatic applyStimulus(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic [31:0] sdata, input logic exp_mem);
      aluop_i    = op;
      wd_i       = wd;
      wreg_i     = wreg;
      wdata_i    = wdata;
      sdata_i    = sdata;
      ex_valid_i = 1'b1;
      #1;
      checkOutput("ready_idle", {31'b0, ex_ready_o}, 32'd1);
      checkOutput("stall_req", {31'b0, stall_req_o}, {31'b0, exp_mem});
      @(posedge clk);
      @(negedge clk);
      ex_valid_i = 1'b0;
   endtask

   // Memory side: check the request, hold it for 'delay' cycles, then ack.
   task automatic memTransaction(input logic [31:0] exp_addr, input logic exp_we, input logic [3:0] exp_be,
                                 input logic [31:0] exp_wdata, input int delay,
                                 input logic [31:0] rdata, input logic err);
      checkOutput("dmem_req", {31'b0, dmem_req_o}, 32'd1);
      checkOutput("dmem_we", {31'b0, dmem_we_o}, {31'b0, exp_we});
      checkOutput("dmem_addr", dmem_addr_o, exp_addr);
      checkOutput("dmem_be", {28'b0, dmem_be_o}, {28'b0, exp_be});
      if (exp_we) checkOutput("dmem_wdata", dmem_wdata_o, exp_wdata);
      for (int i = 1; i < delay; i++) begin
         @(negedge clk);
         checkOutput("req_hold", {31'b0, dmem_req_o}, 32'd1);
         checkOutput("addr_hold", dmem_addr_o, exp_addr);
         checkOutput("be_hold", {28'b0, dmem_be_o}, {28'b0, exp_be});
         if (exp_we) checkOutput("wdata_hold", dmem_wdata_o, exp_wdata);
      end
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = rdata;
      dmem_err_i   = err;
      @(posedge clk);
      @(negedge clk);
      dmem_ack_i   = 1'b0;
      dmem_err_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      checkOutput("req_drop", {31'b0, dmem_req_o}, 32'd0);
      checkOutput("wb_after_ack", {31'b0, wb_valid_o}, 32'd1);
      checkOutput("ready_after_ack", {31'b0, ex_ready_o}, 32'd1);
   endtask

   // Scoreboard: every writeback must match the oldest queued expectation.
   always @(negedge clk) begin
      if (running) begin
         if (wb_valid_o) begin
            if (sb_queue.size() == 0) begin
               checkOutput("unexpected_wb", 32'd1, 32'd0);
            end else begin
               wb_exp_t e;
               e = sb_queue.pop_front();
               checkOutput("wd_o", {27'b0, wd_o}, {27'b0, e.wd});
               checkOutput("wreg_o", {31'b0, wreg_o}, {31'b0, e.wreg});
               checkOutput("wdata_o", wdata_o, e.wdata);
               checkOutput("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
               checkOutput("buserr_o", {31'b0, buserr_o}, {31'b0, e.berr});
            end
         end else begin
            checkOutput("idle_pulses", {29'b0, wreg_o, misalign_o, buserr_o}, 32'd0);
         end
      end
   end

   initial begin
      rst          = 1'b0;
      ex_valid_i   = 1'b0;
      aluop_i      = 8'h0;
      wd_i         = 5'd0;
      wreg_i       = 1'b0;
      wdata_i      = 32'h0;
      sdata_i      = 32'h0;
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      dmem_err_i   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_dmem_req", {31'b0, dmem_req_o}, 32'd0);
      checkOutput("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
      checkOutput("rst_wreg", {31'b0, wreg_o}, 32'd0);
      checkOutput("rst_wdata", wdata_o, 32'd0);
      checkOutput("rst_ready", {31'b0, ex_ready_o}, 32'd1);
      rst     = 1'b1;
      running = 1'b1;

      // OR result straight through, accepted on the first edge after reset
      pushWb(5'd5, 1'b1, 32'h0000_00F0, 1'b0, 1'b0);
      model_wdata = 32'h0000_00F0;
      applyStimulus(OP_OR, 5'd5, 1'b1, 32'h0000_00F0, 32'h0, 1'b0);
      checkOutput("or_wb_valid", {31'b0, wb_valid_o}, 32'd1);
      checkOutput("or_no_req", {31'b0, dmem_req_o}, 32'd0);

      // SB to the top lane with a three-cycle ack delay
      pushWb(5'd9, 1'b0, model_wdata, 1'b0, 1'b0);
      applyStimulus(OP_SB, 5'd9, 1'b1, 32'h0000_1003, 32'h0000_00AB, 1'b1);
      memTransaction(32'h0000_1000, 1'b1, 4'b1000, 32'hABAB_ABAB, 3, 32'h0, 1'b0);

      // LB / LBU of lane 1
      pushWb(5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
      model_wdata = 32'hFFFF_FF80;
      applyStimulus(OP_LB, 5'd7, 1'b1, 32'h0000_2001, 32'h0, 1'b1);
      memTransaction(32'h0000_2000, 1'b0, 4'b1111, 32'h0, 1, 32'h1234_80FF, 1'b0);
      pushWb(5'd7, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
      model_wdata = 32'h0000_0080;
      applyStimulus(OP_LBU, 5'd7, 1'b1, 32'h0000_2001, 32'h0, 1'b1);
      memTransaction(32'h0000_2000, 1'b0, 4'b1111, 32'h0, 2, 32'h1234_80FF, 1'b0);

      // Halfword store to the upper lane, then halfword loads
      pushWb(5'd10, 1'b0, model_wdata, 1'b0, 1'b0);
      applyStimulus(OP_SH, 5'd10, 1'b0, 32'h0000_1002, 32'h1234_BEEF, 1'b1);
      memTransaction(32'h0000_1000, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0, 1'b0);
      pushWb(5'd11, 1'b1, 32'h0000_CAFE, 1'b0, 1'b0);
      model_wdata = 32'h0000_CAFE;
      applyStimulus(OP_LHU, 5'd11, 1'b1, 32'h0000_1002, 32'h0, 1'b1);
      memTransaction(32'h0000_1000, 1'b0, 4'b1111, 32'h0, 1, 32'hCAFE_1234, 1'b0);
      pushWb(5'd12, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0);
      model_wdata = 32'hFFFF_8001;
      applyStimulus(OP_LH, 5'd12, 1'b1, 32'h0000_1000, 32'h0, 1'b1);
      memTransaction(32'h0000_1000, 1'b0, 4'b1111, 32'h0, 1, 32'h1234_8001, 1'b0);

      // Misaligned LW: no request, misalign pulse
      pushWb(5'd3, 1'b0, model_wdata, 1'b1, 1'b0);
      applyStimulus(OP_LW, 5'd3, 1'b1, 32'h0000_2002, 32'h0, 1'b1);
      checkOutput("mis_no_req", {31'b0, dmem_req_o}, 32'd0);
      checkOutput("mis_ready", {31'b0, ex_ready_o}, 32'd1);

      // SW answered with a bus error
      pushWb(5'd13, 1'b0, model_wdata, 1'b0, 1'b1);
      applyStimulus(OP_SW, 5'd13, 1'b1, 32'h0000_3000, 32'h1122_3344, 1'b1);
      memTransaction(32'h0000_3000, 1'b1, 4'b1111, 32'h1122_3344, 2, 32'h0, 1'b1);

      // LW with an ex result offered while busy; the offer must be dropped
      pushWb(5'd4, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      model_wdata = 32'hDEAD_BEEF;
      applyStimulus(OP_LW, 5'd4, 1'b1, 32'h0000_4000, 32'h0, 1'b1);
      aluop_i    = OP_OR;
      wd_i       = 5'd6;
      wreg_i     = 1'b1;
      wdata_i    = 32'h0000_0666;
      ex_valid_i = 1'b1;
      #1;
      checkOutput("busy_not_ready", {31'b0, ex_ready_o}, 32'd0);
      checkOutput("busy_stall", {31'b0, stall_req_o}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      ex_valid_i = 1'b0;
      memTransaction(32'h0000_4000, 1'b0, 4'b1111, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);

      // Reset while busy abandons the load; a late ack is ignored
      applyStimulus(OP_LW, 5'd8, 1'b1, 32'h0000_5000, 32'h0, 1'b1);
      checkOutput("busy_req", {31'b0, dmem_req_o}, 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("midrst_req", {31'b0, dmem_req_o}, 32'd0);
      checkOutput("midrst_ready", {31'b0, ex_ready_o}, 32'd1);
      checkOutput("midrst_wdata", wdata_o, 32'd0);
      model_wdata = 32'h0;
      @(negedge clk);
      rst          = 1'b1;
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'h7777_7777;
      @(posedge clk);
      @(negedge clk);
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      checkOutput("stray_ack_wb", {31'b0, wb_valid_o}, 32'd0);
      checkOutput("stray_ack_req", {31'b0, dmem_req_o}, 32'd0);

      // ADD to x0 never writes
      pushWb(5'd0, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
      applyStimulus(OP_ADD, 5'd0, 1'b1, 32'h0000_0055, 32'h0, 1'b0);
      checkOutput("x0_wb_valid", {31'b0, wb_valid_o}, 32'd1);

      repeat (3) @(negedge clk);
      checkOutput("sb_empty", sb_queue.size(), 32'd0);
      running = 1'b0;
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameters: none; all widths come from the shared package (RegBus=32, RegAddrBus=5, AluOpBus=8).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 ex_valid_i  in  1  ex stage presents a valid result this cycle.
REQ-005 ex_ready_o  out  1  block can accept an ex result this cycle.
REQ-006 aluop_i  in  8  operation code from ex (load/store codes LB,LH,LW,LBU,LHU,SB,SH,SW; all others are non-memory).
REQ-007 wd_i  in  5  destination register address; wreg_i  in  1  destination write enable.
REQ-008 wdata_i  in  32  ex result: ALU value for non-memory ops, effective address for load/store.
REQ-009 sdata_i  in  32  store source register value.
REQ-010 dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32 (word-aligned, [1:0]=00); dmem_be_o  out  4; dmem_wdata_o  out  32.
REQ-011 dmem_ack_i  in  1  completes the request; dmem_rdata_i  in  32  read word, valid with ack; dmem_err_i  in  1  bus error, valid with ack.
REQ-012 wb_valid_o  out  1; wd_o  out  5; wreg_o  out  1; wdata_o  out  32  registered result to writeback.
REQ-013 stall_req_o  out  1  pipeline stall request to controller; misalign_o, buserr_o  out  1 each  single-cycle fault pulses.

Function
REQ-014 FSM states: IDLE, BUSY; ex_ready_o = (state==IDLE); stall_req_o = (state==BUSY) | (state==IDLE & ex_valid_i & load/store op).
REQ-015 Non-memory op accepted in cycle N -> wb_valid_o=1 in N+1 with wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i; state stays IDLE.
REQ-016 wreg_o SHALL be forced 0 whenever wd_o would be 0 (x0 never written).
REQ-017 Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=00; byte ops are always aligned.
REQ-018 Misaligned access accepted in N -> no dmem request; in N+1 wb_valid_o=1, wreg_o=0, misalign_o=1 for one cycle.
REQ-019 Aligned load/store accepted in N -> state BUSY; dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o registered from N+1 and held stable until and including the ack cycle.
REQ-020 Store lanes little-endian: SB be=1<<addr[1:0], wdata={4{byte}}; SH be=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{half}}; SW be=1111.
REQ-021 Loads: dmem_we_o=0, dmem_be_o=1111; on ack the lane selected by addr[1:0] is extracted; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-022 Ack in cycle M -> dmem_req_o=0 in M+1, wb_valid_o=1 in M+1 (load: wdata_o=extended data, wreg_o per REQ-016; store: wreg_o=0), state IDLE in M+1, ex_ready_o=1 in M+1.
REQ-023 dmem_err_i=1 with ack -> same timing as REQ-022 but wreg_o=0 and buserr_o=1 for one cycle.
REQ-024 Ack arriving while IDLE SHALL be ignored; ex_valid_i while BUSY SHALL be ignored (not accepted).
REQ-025 wb_valid_o, misalign_o, buserr_o are single-cycle pulses; wd_o/wreg_o/wdata_o hold last value when wb_valid_o=0 except wreg_o which SHALL be 0.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE and all registered outputs to 0 (dmem_req_o, wb_valid_o, wreg_o, wdata_o, fault pulses).
REQ-027 Reset during BUSY SHALL abandon the outstanding access; a late ack after reset release is ignored per REQ-024.
REQ-028 First acceptance possible in the first clock edge after rst returns to 1.

Structure
REQ-029 Shared package: aluop codes for loads/stores, RegBus/RegAddrBus/AluOpBus widths, ZeroWord, FSM state encoding.
REQ-030 One combinational sub-module lsu_align: byte-enable generation, store data replication, load lane extraction/extension, misalignment detect.

Verification
REQ-031 OR result 0x0000_00F0, wd=5, wreg=1 at N -> N+1 wb_valid=1, wd_o=5, wdata_o=0x0000_00F0, no dmem_req.
REQ-032 SB addr=0x1003, sdata=0x0000_00AB -> dmem_addr=0x1000, be=1000, wdata=0xABAB_ABAB, held through 3-cycle ack delay; wreg_o=0.
REQ-033 LB addr=0x2001, rdata=0x1234_80FF, wd=7 -> wdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080; wb_valid exactly one cycle after ack.
REQ-034 LW addr=0x2002 -> no dmem_req, misalign_o=1, wreg_o=0; SW addr=0x3000 with dmem_err_i=1 on ack -> buserr_o=1, wreg_o=0.
REQ-035 Load in BUSY, rst=0 before ack -> dmem_req_o=0 immediately; after release a stray ack produces no wb_valid; ADD to wd=0 -> wreg_o=0.
